// File: rtl/time_display_scan.sv
// Six-digit multiplexed seven-segment scanner for the BCD clock datapath.
// A time snapshot is taken once per frame so a frame never shows two time values.
`timescale 1ns/1ps
module time_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour_in,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       tick_in,
  output logic [5:0] an_out,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       invalid
);

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [5:0]    AN_OFF    = {6{COMMON_ANODE}};
  localparam logic [6:0]    SEG_OFF   = {7{COMMON_ANODE}};

  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_hour;
  logic [7:0]    r_min;
  logic [7:0]    r_sec;
  logic          r_dp_phase;
  logic          r_invalid;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_term;
  logic          w_wrap;
  logic          w_in_invalid;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_raw;
  logic [5:0]    w_an_raw;
  logic          w_dp_raw;

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  assign w_term = (r_pcnt == PCNT_LAST);
  assign w_wrap = w_term && (r_idx == 3'd5);

  // Judged on the incoming values because they become the shadow on the same edge.
  assign w_in_invalid = bcd_bad(hour_in) || bcd_bad(min_in) || bcd_bad(sec_in) ||
                        (hour_in > 8'h23) || (min_in > 8'h59) || (sec_in > 8'h59);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_nibble = 4'd0;
    case (r_idx)
      3'd0:    w_nibble = r_sec[3:0];
      3'd1:    w_nibble = r_sec[7:4];
      3'd2:    w_nibble = r_min[3:0];
      3'd3:    w_nibble = r_min[7:4];
      3'd4:    w_nibble = r_hour[3:0];
      3'd5:    w_nibble = r_hour[7:4];
      default: w_nibble = 4'd0;
    endcase

    w_seg_raw = 7'b1000000;
    case (w_nibble)
      4'd0:    w_seg_raw = 7'b0111111;
      4'd1:    w_seg_raw = 7'b0000110;
      4'd2:    w_seg_raw = 7'b1011011;
      4'd3:    w_seg_raw = 7'b1001111;
      4'd4:    w_seg_raw = 7'b1100110;
      4'd5:    w_seg_raw = 7'b1101101;
      4'd6:    w_seg_raw = 7'b1111101;
      4'd7:    w_seg_raw = 7'b0000111;
      4'd8:    w_seg_raw = 7'b1111111;
      4'd9:    w_seg_raw = 7'b1101111;
      default: w_seg_raw = 7'b1000000;
    endcase
    if ((r_idx == 3'd5) && (r_hour[7:4] == 4'd0)) w_seg_raw = 7'b0000000;

    w_an_raw = 6'(1) << r_idx;
    w_dp_raw = r_dp_phase && ((r_idx == 3'd2) || (r_idx == 3'd4));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt     <= '0;
      r_idx      <= 3'd0;
      // NOTE: the shadows are reset on purpose: the first frame must show a defined all-zero time.
      r_hour     <= 8'h00;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_dp_phase <= 1'b0;
      r_invalid  <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_OFF;
      r_dp       <= COMMON_ANODE;
    end else begin
      if (w_term) begin
        r_pcnt <= '0;
        r_idx  <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end

      if (w_wrap) begin
        r_hour    <= hour_in;
        r_min     <= min_in;
        r_sec     <= sec_in;
        r_invalid <= w_in_invalid;
      end

      if (tick_in) r_dp_phase <= ~r_dp_phase;

      // Polarity is applied only here, so internal logic is always active-high.
      r_an  <= w_an_raw ^ AN_OFF;
      r_seg <= w_seg_raw ^ SEG_OFF;
      r_dp  <= w_dp_raw ^ COMMON_ANODE;
    end
  end

  assign an_out  = r_an;
  assign seg_out = r_seg;
  assign dp_out  = r_dp;
  assign invalid = r_invalid;

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Multiplexed six-digit seven-segment driver for the clock datapath. It consumes the packed-BCD hour, minute and second bytes produced by the counter chain, plus the seconds carry pulse. It scans them onto a common-anode or common-cathode display with a blinking separator. It is the reader side of the BCD `time_out`/`clk_out` interface and sits between the counter chain and the board pins.

## Interface
- `SCAN_DIV`, 50000: clocks each digit stays lit; legal range 2..2^20.
- `COMMON_ANODE`, 1: 1 = anode and segment outputs active-low; 0 = active-high.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hour_in`  in  8  packed BCD hour: [7:4] is tens, [3:0] is ones.
- `min_in`  in  8  packed BCD minute.
- `sec_in`  in  8  packed BCD second.
- `tick_in`  in  1  one-clock carry pulse, once per second.
- `an_out`  out  6  digit enables; bit 0 is the rightmost digit (seconds ones).
- `seg_out`  out  7  segments {g,f,e,d,c,b,a}.
- `dp_out`  out  1  decimal point, used as the separator.
- `invalid`  out  1  the current snapshot holds an illegal time value.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1.
  - At the terminal value (`pcnt` = SCAN_DIV-1), `pcnt` returns to 0 and digit index `idx` advances.
  - `idx` sequence is 0,1,2,3,4,5,0…; it wraps 5→0.
- Digit map:
  - `idx` 0 = sec[3:0], 1 = sec[7:4]
  - `idx` 2 = min[3:0], 3 = min[7:4]
  - `idx` 4 = hour[3:0], 5 = hour[7:4]
- Snapshot:
  - `hour_in`/`min_in`/`sec_in` are copied into shadow registers only at frame wrap (the terminal count with `idx`=5).
  - The display never mixes two time values within one frame.
- Decode, using the shadow nibble:
  - 0–9 → standard segment patterns.
  - 0xA–0xF → dash (segment g only).
- Blanking: when `idx`=5 and the hour tens nibble is 0, all segments are off; the anode stays enabled.
- Separator:
  - `dp_phase` toggles on every `tick_in` pulse.
  - `dp_out` is active when `dp_phase`=1 and `idx` is 2 or 4; otherwise inactive.
- Exactly one anode bit is active at any time after reset; the active bit is `an_out`[idx].
- Polarity:
  - "Active" means 0 when `COMMON_ANODE`=1 and 1 when `COMMON_ANODE`=0.
  - Polarity inversion is applied at the output register stage only.
- `invalid` is registered and re-evaluated at each snapshot load. It is 1 if any of the following holds:
  - any shadow nibble > 9;
  - hour > 0x23;
  - min > 0x59;
  - sec > 0x59.
- `tick_in` and the prescaler terminal count are independent. When they coincide in the same cycle, both take effect.

## Timing
- Reset, on any edge with `reset`=1:
  - `pcnt`, `idx`, shadows, `dp_phase` and `invalid` all go to 0.
  - `an_out`, `seg_out` and `dp_out` are driven inactive on that same edge.
  - Reset asserted mid-frame aborts the scan immediately; there is no partial-frame completion.
- Outputs are registered from `idx`/shadow, so they have 1-clock latency:
  - `an_out`/`seg_out`/`dp_out` change one clock after `idx` changes.
  - First cycle after reset release: outputs are still inactive. From the second cycle, digit 0 is shown.
- First frame after reset displays the zeroed shadow: seconds "00", minutes "00", hour ones "0", hour tens blank.
- Snapshot and `invalid` update on the same edge as the 5→0 `idx` wrap. The new values are visible on outputs from the following clock.
- A full frame lasts 6·SCAN_DIV clocks. Every digit is lit for exactly SCAN_DIV consecutive output cycles.
- A `dp_phase` toggle on a `tick_in` edge affects `dp_out` one clock later.
- There is no glitch state: `an_out` transitions directly from one one-hot (or one-cold) code to the next.

## Test plan
- Reset release, SCAN_DIV=4, `COMMON_ANODE`=1:
  - During reset: `an_out`=6'b111111, `seg_out`=7'b1111111, `dp_out`=1.
  - One clock after release: `an_out`=6'b111110 and the seg pattern for "0", held for 4 clocks.
  - Hour tens digit is all segments off.
- Inputs hour=0x23, min=0x45, sec=0x59 applied mid-frame:
  - Before the wrap, the current frame still shows zeros.
  - After the wrap, digits 0..5 show 9,5,5,4,3,2, each for 4 clocks; `invalid`=0.
- `tick_in` pulsed once: `dp_out` is active (0) only while `an_out` selects digits 2 and 4. A second pulse turns it off.
- Illegal input hour=0x2A or min=0x60: after the next wrap `invalid`=1. A nibble of 0xA shows as a dash (`seg_out`=7'b0111111 active-low).
- `reset` asserted during `idx`=3:
  - Next edge: all outputs inactive, `idx`=0, shadows cleared.
  - Scan then restarts with the digit 0 timing identical to the first scenario.
- `COMMON_ANODE`=0 rerun of the second scenario: `an_out` and `seg_out` are the bitwise inverse, with identical timing.
